// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: byte handshake between the bus wrapper and the TX core.
// master = wrapper side, slave = uart_tx_core side.
interface uart_tx_core_if;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready
  );
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 UART transmitter, LSB first, line idles high.
// Optional even-parity bit when UART_TX_PARITY_EN is defined (8E1).
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_core_if.slave  bus,
  output logic           o_uart_tx
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end     = (cnt_q == CNT_MAX);
  assign bus.o_ready = (state_q == S_IDLE);
  assign o_uart_tx   = tx_q;

  // State, bit timer, shift register and registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // Next state; the line value for each bit is set at its boundary.
  // The shift register rotates so the full byte survives for parity.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        tx_d  = 1'b1;
        if (bus.i_valid) begin
          shreg_d = bus.i_data;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = {shreg_q[0], shreg_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = ^shreg_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed checks of uart_tx_core at CLKS_PER_BIT=4.
// Frames are sampled at bit centres and compared with hand-built frames.
module tb_uart_tx_core;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk;
  logic rst;
  logic tx;
  int   checks;
  int   failures;

  uart_tx_core_if bus ();

  uart_tx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .o_uart_tx (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b01, d, 1'b0};
`endif
  endfunction

  // Called one sample after the accept edge (cycle k=1).
  // Returns centre samples and number of busy cycles.
  task automatic capture(input int vdrop, output logic [10:0] bits,
                         output int busy);
    int k;
    k = 1;
    bits = '0;
    while (bus.o_ready === 1'b0 && k <= 200) begin
      if (k == vdrop) bus.i_valid = 1'b0;
      if ((k - 1) % CPB == CPB / 2 && (k - 1) / CPB < NB)
        bits[(k - 1) / CPB] = tx;
      tick();
      k++;
    end
    busy = k - 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data = 8'h00;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || bus.o_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: tx=%b ready=%b want 1 1",
                 i, tx, bus.o_ready);
      end
    end
    bus.i_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (tx !== 1'b1 || bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: tx=%b ready=%b want 1 1",
               tx, bus.o_ready);
    end
  endtask

  task automatic test_send_55();
    logic [10:0] b;
    int busy;
    bus.i_data = 8'h55;
    bus.i_valid = 1'b1;
    tick();
    checks++;
    if (tx !== 1'b0 || bus.o_ready !== 1'b0) begin
      failures++;
      $display("FAIL start_55: tx=%b ready=%b want 0 0",
               tx, bus.o_ready);
    end
    capture(1, b, busy);
    checks++;
    if (b !== exp_frame(8'h55)) begin
      failures++;
      $display("FAIL frame_55: got %h want %h", b, exp_frame(8'h55));
    end
    checks++;
    if (busy !== NB * CPB) begin
      failures++;
      $display("FAIL busy_55: got %0d want %0d", busy, NB * CPB);
    end
  endtask

  task automatic test_data_hold();
    logic [10:0] b;
    int busy;
    bus.i_data = 8'hA3;
    bus.i_valid = 1'b1;
    tick();
    bus.i_data = 8'hFF;
    capture(1, b, busy);
    checks++;
    if (b !== exp_frame(8'hA3)) begin
      failures++;
      $display("FAIL frame_a3: got %h want %h", b, exp_frame(8'hA3));
    end
  endtask

  task automatic test_busy_ignore();
    logic [10:0] b;
    int busy;
    bus.i_data = 8'h3C;
    bus.i_valid = 1'b1;
    tick();
    bus.i_data = 8'hC3;
    capture(6, b, busy);
    checks++;
    if (b !== exp_frame(8'h3C)) begin
      failures++;
      $display("FAIL frame_3c: got %h want %h", b, exp_frame(8'h3C));
    end
    checks++;
    if (busy !== NB * CPB) begin
      failures++;
      $display("FAIL busy_3c: got %0d want %0d", busy, NB * CPB);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || bus.o_ready !== 1'b1) begin
        failures++;
        $display("FAIL no_queue cyc%0d: tx=%b ready=%b want 1 1",
                 i, tx, bus.o_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] b1, b2;
    int busy1, busy2;
    bus.i_data = 8'h00;
    bus.i_valid = 1'b1;
    tick();
    bus.i_data = 8'hFF;
    capture(0, b1, busy1);
    checks++;
    if (b1 !== exp_frame(8'h00)) begin
      failures++;
      $display("FAIL b2b_frame1: got %h want %h", b1, exp_frame(8'h00));
    end
    checks++;
    if (busy1 !== NB * CPB || tx !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap: busy=%0d tx=%b want %0d 1",
               busy1, tx, NB * CPB);
    end
    tick();
    checks++;
    if (tx !== 1'b0 || bus.o_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_start2: tx=%b ready=%b want 0 0",
               tx, bus.o_ready);
    end
    capture(1, b2, busy2);
    checks++;
    if (b2 !== exp_frame(8'hFF)) begin
      failures++;
      $display("FAIL b2b_frame2: got %h want %h", b2, exp_frame(8'hFF));
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] b;
    int busy;
    bus.i_data = 8'h0F;
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    for (int i = 0; i < 4 * CPB + 1; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1 || bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: tx=%b ready=%b want 1 1",
               tx, bus.o_ready);
    end
    tick();
    checks++;
    if (tx !== 1'b1 || bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_idle: tx=%b ready=%b want 1 1",
               tx, bus.o_ready);
    end
    bus.i_data = 8'h81;
    bus.i_valid = 1'b1;
    tick();
    capture(1, b, busy);
    checks++;
    if (b !== exp_frame(8'h81)) begin
      failures++;
      $display("FAIL frame_81: got %h want %h", b, exp_frame(8'h81));
    end
    checks++;
    if (busy !== NB * CPB) begin
      failures++;
      $display("FAIL busy_81: got %0d want %0d", busy, NB * CPB);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] b;
    int busy;
    bus.i_data = 8'h07;
    bus.i_valid = 1'b1;
    tick();
    capture(1, b, busy);
    checks++;
    if (b[9] !== 1'b1 || busy !== 44) begin
      failures++;
      $display("FAIL parity_07: bit=%b busy=%0d want 1 44", b[9], busy);
    end
    bus.i_data = 8'h03;
    bus.i_valid = 1'b1;
    tick();
    capture(1, b, busy);
    checks++;
    if (b[9] !== 1'b0 || b !== exp_frame(8'h03)) begin
      failures++;
      $display("FAIL parity_03: got %h want %h", b, exp_frame(8'h03));
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data = 8'h00;
    test_reset();
    test_send_55();
    tick();
    test_data_hold();
    tick();
    test_busy_ignore();
    test_back_to_back();
    tick();
    test_reset_mid_frame();
    tick();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
